// File: rtl/response_frame_builder_pkg.sv
// Shared constants for the response frame builder: framing bytes, the escape
// rule and the control FSM state encoding.
package response_frame_builder_pkg;

  localparam logic [7:0] FRAME_BYTE  = 8'h7E;
  localparam logic [7:0] ESCAPE_BYTE = 8'h7D;
  localparam logic [7:0] ESCAPE_XOR  = 8'h20;

  // The escaped second half lives inside the byte stuffer, so the control FSM
  // needs no separate escape state.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SEND_START = 3'd1;
  localparam logic [2:0] ST_COLLECT    = 3'd2;
  localparam logic [2:0] ST_EMIT       = 3'd3;
  localparam logic [2:0] ST_TAIL       = 3'd4;
  localparam logic [2:0] ST_WAIT_CLOCK = 3'd5;
  localparam logic [2:0] ST_CLOCK_BYTE = 3'd6;
  localparam logic [2:0] ST_SEND_END   = 3'd7;

  function automatic logic needs_escape(input logic [7:0] value);
    return (value == FRAME_BYTE) || (value == ESCAPE_BYTE);
  endfunction

endpackage

// File: rtl/response_frame_builder_if.sv
// Result-bit stream, cycle-count stream and UART byte stream of the
// response frame builder, bundled with producer/consumer views.
interface response_frame_builder_if #(
  parameter int CLOCK_WIDTH = 32
);
  logic                   packet_data;
  logic                   packet_valid;
  logic                   packet_ready;
  logic                   packet_last;
  logic [CLOCK_WIDTH-1:0] clock_data;
  logic                   clock_valid;
  logic                   clock_ready;
  logic [7:0]             uart_data;
  logic                   uart_valid;
  logic                   uart_ready;

  modport master (
    output packet_data, packet_valid, packet_last,
    output clock_data, clock_valid,
    output uart_ready,
    input  packet_ready, clock_ready, uart_data, uart_valid
  );

  modport slave (
    input  packet_data, packet_valid, packet_last,
    input  clock_data, clock_valid,
    input  uart_ready,
    output packet_ready, clock_ready, uart_data, uart_valid
  );
endinterface

// File: rtl/response_frame_builder_byte_stuffer.sv
// Registered byte output stage: escapes FRAME/ESCAPE bytes unless flagged raw,
// and holds the output stable until the consumer takes it.
module response_frame_builder_byte_stuffer
  import response_frame_builder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_raw,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       pend_reg, pend_next;
  logic [7:0] pend_data_reg, pend_data_next;
  logic       load;

  // The output register may be refilled when empty or being taken this cycle;
  // a pending escaped byte has priority over new input.
  assign load     = !valid_reg || out_ready;
  assign in_ready = load && !pend_reg;

  always_comb begin
    data_next      = data_reg;
    valid_next     = valid_reg;
    pend_next      = pend_reg;
    pend_data_next = pend_data_reg;
    if (load) begin
      if (pend_reg) begin
        data_next  = pend_data_reg;
        valid_next = 1'b1;
        pend_next  = 1'b0;
      end else if (in_valid) begin
        valid_next = 1'b1;
        if (!in_raw && needs_escape(in_data)) begin
          data_next      = ESCAPE_BYTE;
          pend_next      = 1'b1;
          pend_data_next = in_data ^ ESCAPE_XOR;
        end else begin
          data_next = in_data;
        end
      end else begin
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      pend_reg      <= 1'b0;
      pend_data_reg <= 8'h00;
    end else begin
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      pend_reg      <= pend_next;
      pend_data_reg <= pend_data_next;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/response_frame_builder.sv
// Packs the processed result bit stream LSB-first into bytes and emits one
// byte-stuffed frame per packet: start, payload, tail, cycle count, end.
module response_frame_builder
  import response_frame_builder_pkg::*;
#(
  parameter int CLOCK_WIDTH = 32
) (
  input logic                    clock,
  input logic                    reset,
  response_frame_builder_if.slave bus
);

  localparam int NB    = CLOCK_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  logic [2:0]             state_reg, state_next;
  logic [7:0]             acc_reg, acc_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic                   last_seen_reg, last_seen_next;
  logic [CLOCK_WIDTH-1:0] clock_reg, clock_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [7:0]             clock_bytes [NB];

  logic [7:0] stuff_data;
  logic       stuff_raw;
  logic       stuff_valid;
  logic       stuff_ready;
  logic       pkt_ready;
  logic       clk_ready;

  for (genvar gi = 0; gi < NB; gi++) begin : g_clock_bytes
    assign clock_bytes[gi] = clock_reg[gi*8 +: 8];
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    last_seen_next = last_seen_reg;
    clock_next     = clock_reg;
    idx_next       = idx_reg;
    stuff_data     = 8'h00;
    stuff_raw      = 1'b0;
    stuff_valid    = 1'b0;
    pkt_ready      = 1'b0;
    clk_ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.packet_valid) state_next = ST_SEND_START;
      end
      ST_SEND_START: begin
        stuff_valid = 1'b1;
        stuff_raw   = 1'b1;
        stuff_data  = FRAME_BYTE;
        if (stuff_ready) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        pkt_ready = 1'b1;
        if (bus.packet_valid) begin
          acc_next = acc_reg | ({7'b0, bus.packet_data} << cnt_reg[2:0]);
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7 || bus.packet_last) begin
            last_seen_next = bus.packet_last;
            state_next     = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        stuff_valid = 1'b1;
        stuff_data  = acc_reg;
        if (stuff_ready) begin
          if (last_seen_reg) begin
            state_next = ST_TAIL;
          end else begin
            acc_next   = 8'h00;
            cnt_next   = 4'd0;
            state_next = ST_COLLECT;
          end
        end
      end
      ST_TAIL: begin
        // The bit count of the final byte is still held in cnt_reg here.
        stuff_valid = 1'b1;
        stuff_raw   = 1'b1;
        stuff_data  = {4'h0, cnt_reg};
        if (stuff_ready) begin
          acc_next       = 8'h00;
          cnt_next       = 4'd0;
          last_seen_next = 1'b0;
          state_next     = ST_WAIT_CLOCK;
        end
      end
      ST_WAIT_CLOCK: begin
        clk_ready = 1'b1;
        if (bus.clock_valid) begin
          clock_next  = bus.clock_data;
          // Offer byte 0 straight away so the UART stream has no bubble.
          stuff_valid = 1'b1;
          stuff_data  = bus.clock_data[7:0];
          if (stuff_ready) begin
            if (LAST_IDX == '0) begin
              state_next = ST_SEND_END;
            end else begin
              idx_next   = IDX_W'(1);
              state_next = ST_CLOCK_BYTE;
            end
          end else begin
            idx_next   = '0;
            state_next = ST_CLOCK_BYTE;
          end
        end
      end
      ST_CLOCK_BYTE: begin
        stuff_valid = 1'b1;
        stuff_data  = clock_bytes[idx_reg];
        if (stuff_ready) begin
          if (idx_reg == LAST_IDX) state_next = ST_SEND_END;
          else                     idx_next   = idx_reg + IDX_W'(1);
        end
      end
      ST_SEND_END: begin
        stuff_valid = 1'b1;
        stuff_raw   = 1'b1;
        stuff_data  = FRAME_BYTE;
        if (stuff_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= 8'h00;
      cnt_reg       <= 4'd0;
      last_seen_reg <= 1'b0;
      clock_reg     <= '0;
      idx_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      last_seen_reg <= last_seen_next;
      clock_reg     <= clock_next;
      idx_reg       <= idx_next;
    end
  end

  assign bus.packet_ready = pkt_ready;
  assign bus.clock_ready  = clk_ready;

  response_frame_builder_byte_stuffer u_stuffer (
    .clock     (clock),
    .reset     (reset),
    .in_data   (stuff_data),
    .in_raw    (stuff_raw),
    .in_valid  (stuff_valid),
    .in_ready  (stuff_ready),
    .out_data  (bus.uart_data),
    .out_valid (bus.uart_valid),
    .out_ready (bus.uart_ready)
  );

endmodule
